// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// This package holds the shared constants and types for the shared memory-port
// arbiter:
//   - data/address widths (INSTR_SIZE, REG_SIZE)
//   - default starvation limit and timeout
//   - the arbiter FSM state encoding
package mem_port_arbiter_pkg;

   localparam int INSTR_SIZE     = 32;
   localparam int REG_SIZE       = 32;
   localparam int DEF_STARVE_MAX = 4;
   localparam int DEF_TIMEOUT    = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_ME_BUSY = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// This block arbitrates a single shared memory port between the fetch stage
// (if_*) and the memory stage (me_*).
//
// Arbitration policy:
//   - The memory stage normally wins.
//   - A starvation counter forces a fetch grant after STARVE_MAX consecutive
//     memory-stage grants that were made while a fetch was waiting.
//   - A busy transaction that sees no mem_ready for TIMEOUT cycles is aborted
//     with an err pulse.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_valid            fetched word, one-cycle completion pulse
//   me_req/me_we/me_addr/me_wdata  memory-stage request
//   me_rdata/me_valid            load data, one-cycle completion pulse
//   mem_cs/mem_we/mem_addr/mem_wdata  shared-port request outputs
//   mem_rdata/mem_ready          shared-port response
//   stall_if/stall_me            pipeline stalls (combinational)
//   err                          one-cycle timeout pulse
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [REG_SIZE-1:0]   if_addr,
   output logic [INSTR_SIZE-1:0] if_rdata,
   output logic                  if_valid,
   input  logic                  me_req,
   input  logic                  me_we,
   input  logic [REG_SIZE-1:0]   me_addr,
   input  logic [REG_SIZE-1:0]   me_wdata,
   output logic [REG_SIZE-1:0]   me_rdata,
   output logic                  me_valid,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [REG_SIZE-1:0]   mem_addr,
   output logic [REG_SIZE-1:0]   mem_wdata,
   input  logic [REG_SIZE-1:0]   mem_rdata,
   input  logic                  mem_ready,
   output logic                  stall_if,
   output logic                  stall_me,
   output logic                  err
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);
   // The abort fires on the busy cycle in which the counter would reach TIMEOUT.
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   arb_state_t state, state_next;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [REG_SIZE-1:0] addr_lat, wdata_lat;
   logic we_lat;
   logic grant_if, grant_me, done, abort, busy;

   assign busy = (state != ST_IDLE);

   // Next-state logic: memory stage has priority unless fetch has been starved.
   always_comb begin
      state_next = state;
      grant_if   = 1'b0;
      grant_me   = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (me_req && !(if_req && starve_cnt == STARVE_LIMIT)) begin
               grant_me   = 1'b1;
               state_next = ST_ME_BUSY;
            end else if (if_req) begin
               grant_if   = 1'b1;
               state_next = ST_IF_BUSY;
            end
         end
         ST_IF_BUSY, ST_ME_BUSY: begin
            if (mem_ready) begin
               done       = 1'b1;
               state_next = ST_IDLE;
            end else if (tmo_cnt == TIMEOUT_LAST) begin
               abort      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, counters, request latches and registered completion outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         addr_lat   <= '0;
         wdata_lat  <= '0;
         we_lat     <= 1'b0;
         if_valid   <= 1'b0;
         me_valid   <= 1'b0;
         err        <= 1'b0;
         if_rdata   <= '0;
         me_rdata   <= '0;
      end else begin
         state <= state_next;

         if (grant_me) begin
            addr_lat  <= me_addr;
            wdata_lat <= me_wdata;
            we_lat    <= me_we;
            if (if_req && starve_cnt != STARVE_LIMIT) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else if (grant_if) begin
            addr_lat   <= if_addr;
            wdata_lat  <= '0;
            we_lat     <= 1'b0;
            starve_cnt <= '0;
         end

         if (grant_me || grant_if) begin
            tmo_cnt <= '0;
         end else if (busy && !mem_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         if_valid <= (done || abort) && (state == ST_IF_BUSY);
         me_valid <= (done || abort) && (state == ST_ME_BUSY);
         err      <= abort;

         // A timeout leaves read data untouched; a store never updates me_rdata.
         if (done && state == ST_IF_BUSY) begin
            if_rdata <= mem_rdata;
         end
         if (done && state == ST_ME_BUSY && !we_lat) begin
            me_rdata <= mem_rdata;
         end
      end
   end

   assign mem_cs    = busy;
   assign mem_we    = (state == ST_ME_BUSY) && we_lat;
   assign mem_addr  = busy ? addr_lat : '0;
   assign mem_wdata = busy ? wdata_lat : '0;

   assign stall_if = if_req && !if_valid;
   assign stall_me = me_req && !me_valid;

endmodule
